// File: rtl/seq_divider_4bit.sv
// seq_divider_4bit: multi-cycle unsigned restoring divider.
// One quotient bit per clock, results held until the next completion.
module seq_divider_4bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] qw_q, qw_d;
    logic [WIDTH-1:0] dw_q, dw_d;
    logic [WIDTH:0]   rw_q, rw_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   diff;
    logic [WIDTH:0]   r_next;
    logic [WIDTH-1:0] q_next;
    logic             borrow;

    // One restoring step: shift in the next dividend bit, trial-subtract.
    always_comb begin
        r_shift = {rw_q[WIDTH-1:0], qw_q[WIDTH-1]};
        diff    = r_shift - {1'b0, dw_q};
        borrow  = diff[WIDTH];
        r_next  = borrow ? r_shift : diff;
        q_next  = {qw_q[WIDTH-2:0], ~borrow};
    end

    // Next-state and output logic; done defaults low so it pulses once.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        qw_d    = qw_q;
        dw_d    = dw_q;
        rw_d    = rw_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    qw_d    = dividend;
                    dw_d    = divisor;
                    rw_d    = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                rw_d  = r_next;
                qw_d  = q_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    quot_d  = q_next;
                    rem_d   = r_next[WIDTH-1:0];
                    dbz_d   = (dw_q == '0);
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            qw_q    <= '0;
            dw_q    <= '0;
            rw_q    <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            qw_q    <= qw_d;
            dw_q    <= dw_d;
            rw_q    <= rw_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_4bit.sv
// tb_seq_divider_4bit: directed and randomized checks of the
// sequential divider against a plain-arithmetic reference.
module tb_seq_divider_4bit;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    int checks;
    int passes;
    int done_seen;
    int exp_dones;

    seq_divider_4bit #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every done cycle, sampled away from the active edge.
    always @(negedge clk) begin
        if (done === 1'b1) done_seen++;
    end

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    endtask

    // Caller is just past a negedge; start is sampled at the next posedge.
    task automatic start_op(input int a, input int b);
        dividend = WIDTH'(a);
        divisor  = WIDTH'(b);
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_accept", busy, 1);
        check("done_one_cycle", done, 0);
    endtask

    // Waits from the negedge after the accepting edge until done.
    task automatic wait_done(input int a, input int b);
        int eq;
        int er;
        int k;
        eq = (b == 0) ? (1 << WIDTH) - 1 : a / b;
        er = (b == 0) ? a : a % b;
        for (k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (done === 1'b1) break;
        end
        exp_dones++;
        check("latency", k, WIDTH);
        check("quotient", quotient, eq);
        check("remainder", remainder, er);
        check("div_by_zero", div_by_zero, (b == 0) ? 1 : 0);
        check("busy_at_done", busy, 0);
    endtask

    initial begin
        checks    = 0;
        passes    = 0;
        done_seen = 0;
        exp_dones = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(negedge clk);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dbz", div_by_zero, 0);
        rst_n = 1'b1;
        @(negedge clk);

        start_op(13, 3);
        wait_done(13, 3);
        start_op(7, 0);
        wait_done(7, 0);
        start_op(15, 1);
        wait_done(15, 1);
        start_op(2, 9);
        wait_done(2, 9);
        start_op(0, 5);
        wait_done(0, 5);
        start_op(9, 9);
        wait_done(9, 9);

        dividend = 4'd13;
        divisor  = 4'd3;
        start    = 1'b1;
        @(negedge clk);
        dividend = 4'd8;
        divisor  = 4'd2;
        check("busy_hold_start", busy, 1);
        wait_done(13, 3);
        @(negedge clk);
        start = 1'b0;
        check("b2b_accept_busy", busy, 1);
        check("held_quotient", quotient, 4);
        check("held_remainder", remainder, 1);
        check("b2b_done_low", done, 0);
        wait_done(8, 2);

        start_op(11, 2);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_quotient", quotient, 0);
        check("abort_remainder", remainder, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_dbz", div_by_zero, 0);
        repeat (2) begin
            @(negedge clk);
            check("abort_no_done", done, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        start_op(11, 2);
        wait_done(11, 2);

        for (int i = 0; i < 24; i++) begin
            int a;
            int b;
            a = int'($urandom_range(0, 15));
            b = int'($urandom_range(0, 15));
            start_op(a, b);
            wait_done(a, b);
        end

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                start_op(a, b);
                wait_done(a, b);
            end
        end

        repeat (3) @(negedge clk);
        check("done_count", done_seen, exp_dones);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
